stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 93 +++++++++
 tb/tb_stream_mux_rr.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with one output register stage.
// Channel choice is manual (sel) or round-robin after the last served channel.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SLOTS = 1 << SEL_W;

  logic             load_en;
  logic             grant;
  logic [SEL_W-1:0] grant_idx;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] ptr;
  logic [SLOTS-1:0] valid_pad;
  logic [WIDTH-1:0] ch_data [SLOTS];

  // Pad to a power of two so any sel value indexes safely; pads never grant.
  always_comb begin
    valid_pad = '0;
    valid_pad[N-1:0] = in_valid;
    for (int i = 0; i < SLOTS; i++) begin
      ch_data[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = SEL_W'((int'(ptr) + k) % N);
      if (valid_pad[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    load_en = !out_valid || out_ready;
    if (mode) begin
      grant = rr_hit;
      grant_idx = rr_idx;
    end else begin
      grant = valid_pad[sel];
      grant_idx = sel;
    end
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load_en && grant
                    && (grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= SEL_W'(N - 1);
    end else if (load_en) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data <= ch_data[grant_idx];
        out_ch <= grant_idx;
        ptr <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: three parameter sets against one
// behavioural arbitration model, plus directed literal scenarios.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  // d0: WIDTH=8 N=4
  logic [31:0] in_data0;
  logic [3:0]  in_valid0, in_ready0;
  logic        mode0, out_ready0, out_valid0;
  logic [1:0]  sel0, out_ch0;
  logic [7:0]  out_data0;
  // d1: WIDTH=1 N=2
  logic [1:0]  in_data1, in_valid1, in_ready1;
  logic        mode1, out_ready1, out_valid1;
  logic [0:0]  sel1, out_ch1, out_data1;
  // d2: WIDTH=16 N=5
  logic [79:0] in_data2;
  logic [4:0]  in_valid2, in_ready2;
  logic        mode2, out_ready2, out_valid2;
  logic [2:0]  sel2, out_ch2;
  logic [15:0] out_data2;

  stream_mux_rr #(.WIDTH(8), .N(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0),
    .in_valid(in_valid0), .in_ready(in_ready0), .mode(mode0),
    .sel(sel0), .out_data(out_data0), .out_ch(out_ch0),
    .out_valid(out_valid0), .out_ready(out_ready0));

  stream_mux_rr #(.WIDTH(1), .N(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1),
    .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode1),
    .sel(sel1), .out_data(out_data1), .out_ch(out_ch1),
    .out_valid(out_valid1), .out_ready(out_ready1));

  stream_mux_rr #(.WIDTH(16), .N(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .mode(mode2),
    .sel(sel2), .out_data(out_data2), .out_ch(out_ch2),
    .out_valid(out_valid2), .out_ready(out_ready2));

  // model state: what each output register must hold
  int          nn [3] = '{4, 2, 5};
  bit          m_valid [3];
  logic [15:0] m_data [3];
  int          m_ch [3];
  int          m_ptr [3];

  function automatic int arb(int n, int ptr, bit md, int s, int vm);
    if (!md) return (s < n && vm[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (vm[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit mode_of(int d);
    case (d)
      0: return mode0;
      1: return mode1;
      default: return mode2;
    endcase
  endfunction

  function automatic int sel_of(int d);
    case (d)
      0: return int'(sel0);
      1: return int'(sel1);
      default: return int'(sel2);
    endcase
  endfunction

  function automatic int vmask(int d);
    case (d)
      0: return int'(in_valid0);
      1: return int'(in_valid1);
      default: return int'(in_valid2);
    endcase
  endfunction

  function automatic bit rdy_of(int d);
    case (d)
      0: return out_ready0;
      1: return out_ready1;
      default: return out_ready2;
    endcase
  endfunction

  function automatic logic [15:0] data_of(int d, int c);
    case (d)
      0: return 16'(in_data0[c*8 +: 8]);
      1: return 16'(in_data1[c +: 1]);
      default: return in_data2[c*16 +: 16];
    endcase
  endfunction

  function automatic int grant_m(int d);
    return arb(nn[d], m_ptr[d], mode_of(d), sel_of(d), vmask(d));
  endfunction

  function automatic bit load_m(int d);
    return !m_valid[d] || rdy_of(d);
  endfunction

  function automatic int exp_rdy(int d);
    if (rst_n && load_m(d) && grant_m(d) >= 0) return 1 << grant_m(d);
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_valid[d] <= 1'b0;
        m_data[d] <= '0;
        m_ch[d] <= 0;
        m_ptr[d] <= nn[d] - 1;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (load_m(d)) begin
          if (grant_m(d) >= 0) begin
            m_valid[d] <= 1'b1;
            m_data[d] <= data_of(d, grant_m(d));
            m_ch[d] <= grant_m(d);
            m_ptr[d] <= grant_m(d);
          end else begin
            m_valid[d] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("d0.out_valid", 32'(out_valid0), 32'(m_valid[0]));
      check("d0.out_data", 32'(out_data0), 32'(m_data[0]));
      check("d0.out_ch", 32'(out_ch0), m_ch[0]);
      check("d0.in_ready", 32'(in_ready0), exp_rdy(0));
      check("d1.out_valid", 32'(out_valid1), 32'(m_valid[1]));
      check("d1.out_data", 32'(out_data1), 32'(m_data[1]));
      check("d1.out_ch", 32'(out_ch1), m_ch[1]);
      check("d1.in_ready", 32'(in_ready1), exp_rdy(1));
      check("d2.out_valid", 32'(out_valid2), 32'(m_valid[2]));
      check("d2.out_data", 32'(out_data2), 32'(m_data[2]));
      check("d2.out_ch", 32'(out_ch2), m_ch[2]);
      check("d2.in_ready", 32'(in_ready2), exp_rdy(2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_data0 = '0; in_valid0 = '0; mode0 = 1'b0; sel0 = '0; out_ready0 = 1'b1;
    in_data1 = '0; in_valid1 = '0; mode1 = 1'b0; sel1 = '0; out_ready1 = 1'b1;
    in_data2 = '0; in_valid2 = '0; mode2 = 1'b0; sel2 = '0; out_ready2 = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    mode0 = 1'b1;
    in_valid0 = 4'hF;
    in_data0 = 32'hA3A2A1A0;
    #1;
    check("rst.in_ready", 32'(in_ready0), 32'h0);
    check("rst.out_valid", 32'(out_valid0), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // round-robin rotation from reset
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr.ch", 32'(out_ch0), i % 4);
      check("rr.data", 32'(out_data0), 32'hA0 + (i % 4));
    end

    // manual select, channel not valid then valid
    mode0 = 1'b0; sel0 = 2'd2; in_valid0 = 4'b1011;
    #1 check("man.ready0", 32'(in_ready0), 32'h0);
    step();
    check("man.idle1", 32'(out_valid0), 32'h0);
    step();
    check("man.idle2", 32'(out_valid0), 32'h0);
    in_valid0 = 4'b0100;
    in_data0 = 32'h005C0000;
    step();
    check("man.valid", 32'(out_valid0), 32'h1);
    check("man.data", 32'(out_data0), 32'h5C);
    check("man.ch", 32'(out_ch0), 32'h2);

    // backpressure hold then bubble-free reload
    in_data0 = 32'h13121110; sel0 = 2'd1; in_valid0 = 4'b0010;
    step();
    check("bp.load", 32'(out_data0), 32'h11);
    out_ready0 = 1'b0; in_valid0 = 4'hF; mode0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp.ready", 32'(in_ready0), 32'h0);
      step();
      check("bp.hold", 32'(out_data0), 32'h11);
      check("bp.valid", 32'(out_valid0), 32'h1);
    end
    out_ready0 = 1'b1;
    #1 check("bp.grant", 32'(in_ready0), 32'h4);
    step();
    check("bp.next", 32'(out_data0), 32'h12);
    check("bp.nextch", 32'(out_ch0), 32'h2);

    // round-robin after serving the last channel
    in_valid0 = 4'b1000; in_data0 = 32'hF30000E0;
    step();
    check("wrap.3", 32'(out_ch0), 32'h3);
    check("wrap.F3", 32'(out_data0), 32'hF3);
    in_valid0 = 4'b1001;
    step();
    check("wrap.0", 32'(out_ch0), 32'h0);
    step();
    check("wrap.3b", 32'(out_ch0), 32'h3);
    step();
    check("wrap.0b", 32'(out_ch0), 32'h0);

    // half-cycle asynchronous reset pulse
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid0), 32'h0);
    check("arst.data", 32'(out_data0), 32'h0);
    check("arst.ch", 32'(out_ch0), 32'h0);
    check("arst.ready", 32'(in_ready0), 32'h0);
    #4 rst_n = 1'b1;
    mode0 = 1'b1; in_valid0 = 4'hF; in_data0 = 32'hA3A2A1A0;
    step();
    check("arst.first", 32'(out_ch0), 32'h0);
    check("arst.fdata", 32'(out_data0), 32'hA0);

    // WIDTH=1 N=2 round-robin alternation
    mode1 = 1'b1; in_valid1 = 2'b11; in_data1 = 2'b10;
    step();
    check("n2.ch0", 32'(out_ch1), 32'h0);
    check("n2.d0", 32'(out_data1), 32'h0);
    step();
    check("n2.ch1", 32'(out_ch1), 32'h1);
    check("n2.d1", 32'(out_data1), 32'h1);
    step();
    check("n2.ch0b", 32'(out_ch1), 32'h0);

    // WIDTH=16 N=5: out-of-range sel and wrap 4 -> 0
    mode2 = 1'b0; in_valid2 = 5'h1F;
    in_data2 = {16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000};
    for (int s = 5; s < 8; s++) begin
      sel2 = 3'(s);
      #1 check("n5.noready", 32'(in_ready2), 32'h0);
      step();
      check("n5.novalid", 32'(out_valid2), 32'h0);
    end
    sel2 = 3'd4;
    step();
    check("n5.ch4", 32'(out_ch2), 32'h4);
    check("n5.d4", 32'(out_data2), 32'hC004);
    mode2 = 1'b1;
    step();
    check("n5.wrap", 32'(out_ch2), 32'h0);
    check("n5.wdata", 32'(out_data2), 32'hC000);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_data0 = $urandom;
      in_valid0 = 4'($urandom);
      sel0 = 2'($urandom);
      out_ready0 = ($urandom % 4) != 0;
      if ($urandom % 10 == 0) mode0 = ~mode0;
      in_data1 = 2'($urandom);
      in_valid1 = 2'($urandom);
      sel1 = 1'($urandom);
      out_ready1 = ($urandom % 3) != 0;
      if ($urandom % 10 == 0) mode1 = ~mode1;
      in_data2 = 80'({$urandom, $urandom, $urandom});
      in_valid2 = 5'($urandom);
      sel2 = 3'($urandom);
      out_ready2 = ($urandom % 4) != 0;
      if ($urandom % 10 == 0) mode2 = ~mode2;
      step();
    end

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
